// File: rtl/audio_envelope_gen.sv
// Per-voice ADSR envelope generator. One shared datapath visits each voice in turn,
// one voice per cycle, in the sweep that follows each accumulator tick.
module audio_envelope_gen #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned LEVEL_BITS = 8,
   parameter int unsigned PRESC_BITS = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          tick,
   input  logic                          cfg_valid,
   input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
   input  logic [16:0]                   cfg_data,
   output logic [4*NUM_VOICES-1:0]       env_volume,
   output logic                          env_busy
);

   localparam int unsigned VW       = $clog2(NUM_VOICES);
   localparam int unsigned CFG_BITS = 17;
   localparam int unsigned GATE_BIT = 16;
   localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = '1;
   localparam logic [LEVEL_BITS-1:0] LEVEL_ONE = LEVEL_BITS'(1);
   localparam logic [VW-1:0]         LAST_SLOT = VW'(NUM_VOICES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_e;

   env_state_e            state_q [NUM_VOICES];
   env_state_e            state_d [NUM_VOICES];
   logic [LEVEL_BITS-1:0] level_q [NUM_VOICES];
   logic [LEVEL_BITS-1:0] level_d [NUM_VOICES];
   logic [PRESC_BITS-1:0] presc_q [NUM_VOICES];
   logic [PRESC_BITS-1:0] presc_d [NUM_VOICES];
   logic [CFG_BITS-1:0]   cfg_q   [NUM_VOICES];
   logic [CFG_BITS-1:0]   cfg_d   [NUM_VOICES];
   logic [3:0]            vol_q   [NUM_VOICES];
   logic [3:0]            vol_d   [NUM_VOICES];
   logic [NUM_VOICES-1:0] retrig_q, retrig_d;
   logic                  busy_q, busy_d;
   logic [VW-1:0]         slot_q, slot_d;

   env_state_e            cur_state, slot_state;
   logic [LEVEL_BITS-1:0] cur_level, slot_level, sus_target;
   logic [PRESC_BITS-1:0] cur_presc, slot_presc, presc_max, presc_adv;
   logic [CFG_BITS-1:0]   cur_cfg;
   logic [3:0]            rate;
   logic                  cur_retrig, cur_gate, rate_step;

   // State registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            state_q[v] <= ST_IDLE;
            level_q[v] <= '0;
            presc_q[v] <= '0;
            cfg_q[v]   <= '0;
            vol_q[v]   <= '0;
         end
         retrig_q <= '0;
         busy_q   <= 1'b0;
         slot_q   <= '0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         presc_q  <= presc_d;
         cfg_q    <= cfg_d;
         vol_q    <= vol_d;
         retrig_q <= retrig_d;
         busy_q   <= busy_d;
         slot_q   <= slot_d;
      end
   end

   // Shared envelope datapath for the voice owning the current slot
   always_comb begin
      cur_state  = state_q[slot_q];
      cur_level  = level_q[slot_q];
      cur_presc  = presc_q[slot_q];
      cur_cfg    = cfg_q[slot_q];
      cur_retrig = retrig_q[slot_q];
      cur_gate   = cur_cfg[GATE_BIT];
      sus_target = LEVEL_BITS'({cur_cfg[7:4], cur_cfg[7:4]});

      unique case (cur_state)
         ST_ATTACK:  rate = cur_cfg[15:12];
         ST_DECAY:   rate = cur_cfg[11:8];
         ST_RELEASE: rate = cur_cfg[3:0];
         default:    rate = 4'd0;
      endcase
      presc_max = PRESC_BITS'((32'd1 << rate) - 32'd1);
      rate_step = (cur_presc == presc_max);
      presc_adv = rate_step ? '0 : cur_presc + PRESC_BITS'(1);

      slot_state = cur_state;
      slot_level = cur_level;
      slot_presc = cur_presc;

      if (cur_retrig) begin
         // Retrigger restarts the attack from wherever the level currently is
         slot_state = ST_ATTACK;
         slot_presc = '0;
      end else if (!cur_gate && (cur_state == ST_ATTACK || cur_state == ST_DECAY ||
                                 cur_state == ST_SUSTAIN)) begin
         slot_state = ST_RELEASE;
         slot_presc = '0;
      end else begin
         unique case (cur_state)
            ST_IDLE: begin
               slot_level = '0;
            end
            ST_ATTACK: begin
               if (cur_level == LEVEL_MAX) begin
                  slot_state = ST_DECAY;
                  slot_presc = '0;
               end else begin
                  slot_presc = presc_adv;
                  if (rate_step) begin
                     slot_level = cur_level + LEVEL_ONE;
                     if (cur_level == LEVEL_MAX - LEVEL_ONE) begin
                        slot_state = ST_DECAY;
                        slot_presc = '0;
                     end
                  end
               end
            end
            ST_DECAY: begin
               if (cur_level <= sus_target) begin
                  slot_state = ST_SUSTAIN;
                  slot_presc = '0;
               end else begin
                  slot_presc = presc_adv;
                  if (rate_step) slot_level = cur_level - LEVEL_ONE;
               end
            end
            ST_SUSTAIN: begin
               slot_level = cur_level;
            end
            ST_RELEASE: begin
               if (cur_level == '0) begin
                  slot_state = ST_IDLE;
                  slot_presc = '0;
               end else begin
                  slot_presc = presc_adv;
                  if (rate_step) begin
                     slot_level = cur_level - LEVEL_ONE;
                     if (cur_level == LEVEL_ONE) begin
                        slot_state = ST_IDLE;
                        slot_presc = '0;
                     end
                  end
               end
            end
            default: begin
               slot_state = ST_IDLE;
               slot_level = '0;
               slot_presc = '0;
            end
         endcase
      end
   end

   // Sweep sequencing, slot write-back and config writes
   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      presc_d  = presc_q;
      cfg_d    = cfg_q;
      vol_d    = vol_q;
      retrig_d = retrig_q;
      busy_d   = busy_q;
      slot_d   = slot_q;

      if (busy_q) begin
         state_d[slot_q]  = slot_state;
         level_d[slot_q]  = slot_level;
         presc_d[slot_q]  = slot_presc;
         vol_d[slot_q]    = slot_level[LEVEL_BITS-1 -: 4];
         retrig_d[slot_q] = 1'b0;
         if (slot_q == LAST_SLOT) begin
            busy_d = 1'b0;
            slot_d = '0;
         end else begin
            slot_d = slot_q + VW'(1);
         end
      end else if (tick) begin
         busy_d = 1'b1;
         slot_d = '0;
      end

      // A gate rising edge written in the voice's own slot must survive that slot's clear
      if (cfg_valid) begin
         cfg_d[cfg_voice] = cfg_data;
         if (!cfg_q[cfg_voice][GATE_BIT] && cfg_data[GATE_BIT]) retrig_d[cfg_voice] = 1'b1;
      end
   end

   always_comb begin
      env_volume = '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) env_volume[4*v +: 4] = vol_q[v];
   end

   assign env_busy = busy_q;

endmodule
